// File: rtl/tx_seq_pkg.sv
// Shared types and constants for the multi-byte transmit sequencer.
package tx_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/tx_seq_nbyte_if.sv
// Bundle between the packet/command logic, the sequencer and serial8.
// Handshake: trmt is a request taken only while idle (no queuing); send_byte is a
// one-cycle strobe with byte_out valid in that cycle; byte_sent acknowledges it.
interface tx_seq_nbyte_if #(
  parameter int NUM_BYTES = 2,
  parameter int IW        = $clog2(NUM_BYTES)
);
  logic                                   trmt;
  logic [tx_seq_pkg::BYTE_W*NUM_BYTES-1:0] tx_data;
  logic                                   abort;
  logic                                   byte_sent;
  logic [tx_seq_pkg::BYTE_W-1:0]          byte_out;
  logic                                   send_byte;
  logic [IW-1:0]                          byte_idx;
  logic                                   busy;
  logic                                   tx_done;

  modport master (
    output trmt, tx_data, abort, byte_sent,
    input  byte_out, send_byte, byte_idx, busy, tx_done
  );

  modport slave (
    input  trmt, tx_data, abort, byte_sent,
    output byte_out, send_byte, byte_idx, busy, tx_done
  );
endinterface

// File: rtl/tx_shreg.sv
// Load/shift register that presents one byte of a captured word at a time.
module tx_shreg
  import tx_seq_pkg::*;
#(
  parameter int  NUM_BYTES = 2,
  parameter bit  LSB_FIRST = 1'b0,
  localparam int W         = BYTE_W * NUM_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [W-1:0]      din,
  output logic [BYTE_W-1:0] byte_out
);

  logic [W-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift) begin
      if (LSB_FIRST) shreg_d = shreg_q >> BYTE_W;
      else           shreg_d = shreg_q << BYTE_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) shreg_q <= '0;
    else     shreg_q <= shreg_d;
  end

  // The outgoing byte always sits at the end the register shifts towards.
  assign byte_out = LSB_FIRST ? shreg_q[BYTE_W-1:0] : shreg_q[W-1 -: BYTE_W];

endmodule

// File: rtl/tx_seq_nbyte.sv
// Multi-byte transmit sequencer: feeds serial8 one byte per byte_sent, in
// selectable order, with abort. All outputs come straight from flops.
module tx_seq_nbyte
  import tx_seq_pkg::*;
#(
  parameter int  NUM_BYTES = 2,
  parameter bit  LSB_FIRST = 1'b0,
  localparam int IW        = $clog2(NUM_BYTES)
) (
  input  logic        clk,
  input  logic        rst,
  tx_seq_nbyte_if.slave bus,
  output seq_state_t  dbg_state
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

  seq_state_t    state_q, state_d;
  logic          send_q, send_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          load, shift;

  always_comb begin
    state_d = state_q;
    send_d  = 1'b0;
    done_d  = 1'b0;
    idx_d   = idx_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.trmt) begin
          load    = 1'b1;
          idx_d   = '0;
          send_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // abort wins over a coincident byte_sent; byte_sent during the strobe
        // cycle cannot belong to the byte just issued and is dropped.
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.byte_sent && !send_q) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            shift  = 1'b1;
            idx_d  = idx_q + 1'b1;
            send_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
    end
  end

  tx_shreg #(
    .NUM_BYTES (NUM_BYTES),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .din      (bus.tx_data),
    .byte_out (bus.byte_out)
  );

  assign bus.send_byte = send_q;
  assign bus.tx_done   = done_q;
  assign bus.busy      = busy_q;
  assign bus.byte_idx  = idx_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_tx_seq_nbyte.sv
// Directed bench: MSB-first and LSB-first 4-byte sequencers run in lockstep,
// plus a 2-byte instance for back-to-back and ignored byte_sent cases.
module tb_tx_seq_nbyte;
  import tx_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- DUTs ----------------
  logic        s_trmt = 1'b0, s_abort = 1'b0, s_sent = 1'b0;
  logic [31:0] s_data = '0;
  logic        t_trmt = 1'b0, t_sent = 1'b0;
  logic [15:0] t_data = '0;
  seq_state_t  m_state, l_state, t_state;

  tx_seq_nbyte_if #(.NUM_BYTES(4)) m_if ();
  tx_seq_nbyte_if #(.NUM_BYTES(4)) l_if ();
  tx_seq_nbyte_if #(.NUM_BYTES(2)) t_if ();

  assign m_if.trmt = s_trmt;  assign m_if.tx_data = s_data;
  assign m_if.abort = s_abort; assign m_if.byte_sent = s_sent;
  assign l_if.trmt = s_trmt;  assign l_if.tx_data = s_data;
  assign l_if.abort = s_abort; assign l_if.byte_sent = s_sent;
  assign t_if.trmt = t_trmt;  assign t_if.tx_data = t_data;
  assign t_if.abort = 1'b0;    assign t_if.byte_sent = t_sent;

  tx_seq_nbyte #(.NUM_BYTES(4), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .bus(m_if), .dbg_state(m_state));
  tx_seq_nbyte #(.NUM_BYTES(4), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .bus(l_if), .dbg_state(l_state));
  tx_seq_nbyte #(.NUM_BYTES(2), .LSB_FIRST(1'b0)) u_two (
    .clk(clk), .rst(rst), .bus(t_if), .dbg_state(t_state));

  // ---------------- scoreboard ----------------
  logic [7:0] m_exp_q[$], l_exp_q[$], t_exp_q[$];
  logic [3:0] m_idx_q[$], l_idx_q[$], t_idx_q[$];
  int m_sends = 0, l_sends = 0, t_sends = 0;
  int m_dones = 0, l_dones = 0, t_dones = 0;

  always @(negedge clk) begin
    if (m_if.send_byte) begin
      m_sends++;
      if (m_exp_q.size() == 0) check("msb_extra_send", 1, 0);
      else begin
        check("msb_byte", m_if.byte_out, m_exp_q.pop_front());
        check("msb_idx", m_if.byte_idx, m_idx_q.pop_front());
      end
    end
    if (m_if.tx_done) m_dones++;
  end

  always @(negedge clk) begin
    if (l_if.send_byte) begin
      l_sends++;
      if (l_exp_q.size() == 0) check("lsb_extra_send", 1, 0);
      else begin
        check("lsb_byte", l_if.byte_out, l_exp_q.pop_front());
        check("lsb_idx", l_if.byte_idx, l_idx_q.pop_front());
      end
    end
    if (l_if.tx_done) l_dones++;
  end

  always @(negedge clk) begin
    if (t_if.send_byte) begin
      t_sends++;
      if (t_exp_q.size() == 0) check("two_extra_send", 1, 0);
      else begin
        check("two_byte", t_if.byte_out, t_exp_q.pop_front());
        check("two_idx", t_if.byte_idx, t_idx_q.pop_front());
      end
    end
    if (t_if.tx_done) t_dones++;
  end

  // Expected byte order for the first n bytes of word w.
  task automatic push_exp(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      m_exp_q.push_back(w[31-8*i -: 8]);
      m_idx_q.push_back(4'(i));
      l_exp_q.push_back(w[8*i +: 8]);
      l_idx_q.push_back(4'(i));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start(input logic [31:0] w);
    @(negedge clk);
    s_trmt = 1'b1;
    s_data = w;
    @(negedge clk);
    s_trmt = 1'b0;
    check("start_busy", m_if.busy, 1);
  endtask

  // Wait for a strobe, answer byte_sent five cycles later; optionally poke trmt.
  task automatic serve(input bit with_abort, input bit glitch);
    int t;
    t = 0;
    while (!m_if.send_byte && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("send_byte_seen", m_if.send_byte, 1);
    if (glitch) begin
      s_trmt = 1'b1;
      s_data = 32'hFFFF_FFFF;
    end
    @(negedge clk);
    s_trmt = 1'b0;
    repeat (4) @(negedge clk);
    s_sent  = 1'b1;
    s_abort = with_abort;
    @(negedge clk);
    s_sent  = 1'b0;
    s_abort = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_send"}, m_if.send_byte, 0);
    check({tag, "_m_done"}, m_if.tx_done, 0);
    check({tag, "_m_busy"}, m_if.busy, 0);
    check({tag, "_m_idx"}, m_if.byte_idx, 0);
    check({tag, "_m_out"}, m_if.byte_out, 0);
    check({tag, "_m_state"}, m_state, IDLE);
    check({tag, "_l_out"}, l_if.byte_out, 0);
    check({tag, "_l_busy"}, l_if.busy, 0);
  endtask

  // ---------------- stimulus ----------------
  int base_s, base_d;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_two_out", t_if.byte_out, 0);
    rst = 1'b0;

    // MSB / LSB order
    push_exp(32'hA1B2C3D4, 4);
    base_s = m_sends;
    start(32'hA1B2C3D4);
    repeat (4) serve(1'b0, 1'b0);
    check("t1_done", m_if.tx_done, 1);
    check("t1_busy", m_if.busy, 0);
    check("t1_l_done", l_if.tx_done, 1);
    @(negedge clk);
    check("t1_done_pulse", m_if.tx_done, 0);
    check("t1_sends", m_sends - base_s, 4);
    check("t1_l_sends", l_sends - base_s, 4);

    // trmt and tx_data changes while busy are ignored
    push_exp(32'hA1B2C3D4, 4);
    base_s = m_sends;
    start(32'hA1B2C3D4);
    serve(1'b0, 1'b1);
    repeat (3) serve(1'b0, 1'b0);
    check("t3_done", m_if.tx_done, 1);
    repeat (3) @(negedge clk);
    check("t3_sends", m_sends - base_s, 4);
    check("t3_idle", m_state, IDLE);

    // abort coincident with 2nd byte_sent
    push_exp(32'hA1B2C3D4, 2);
    base_s = m_sends;
    base_d = m_dones;
    start(32'hA1B2C3D4);
    serve(1'b0, 1'b0);
    serve(1'b1, 1'b0);
    check("t4_state", m_state, IDLE);
    check("t4_busy", m_if.busy, 0);
    check("t4_done", m_if.tx_done, 0);
    check("t4_l_busy", l_if.busy, 0);
    repeat (10) @(negedge clk);
    check("t4_sends", m_sends - base_s, 2);
    check("t4_no_done", m_dones - base_d, 0);

    // reset right after the 3rd strobe, then a fresh transfer
    push_exp(32'hA1B2C3D4, 3);
    base_s = m_sends;
    start(32'hA1B2C3D4);
    repeat (2) serve(1'b0, 1'b0);
    check("t5_third_send", m_if.send_byte, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("t5_rst");
    check("t5_sends", m_sends - base_s, 3);
    push_exp(32'h01020304, 4);
    start(32'h01020304);
    repeat (4) serve(1'b0, 1'b0);
    check("t5_done", m_if.tx_done, 1);
    check("t5_l_done", l_if.tx_done, 1);
    repeat (2) @(negedge clk);

    // 2-byte: trmt held, byte_sent during strobe, back-to-back start
    t_exp_q = '{8'hAB, 8'hCD, 8'h12, 8'h34};
    t_idx_q = '{4'd0, 4'd1, 4'd0, 4'd1};
    @(negedge clk);
    t_trmt = 1'b1;
    t_data = 16'hABCD;
    @(negedge clk);
    check("t6_send0", t_if.send_byte, 1);
    check("t6_busy0", t_if.busy, 1);
    t_sent = 1'b1;
    t_data = 16'h1234;
    @(negedge clk);
    t_sent = 1'b0;
    check("t6_ignored_send", t_if.send_byte, 0);
    check("t6_ignored_idx", t_if.byte_idx, 0);
    @(negedge clk);
    t_sent = 1'b1;
    @(negedge clk);
    check("t6_send1", t_if.send_byte, 1);
    @(negedge clk);
    check("t6_ignored2", t_if.send_byte, 0);
    check("t6_no_early_done", t_if.tx_done, 0);
    @(negedge clk);
    t_sent = 1'b0;
    check("t6_done", t_if.tx_done, 1);
    check("t6_busy_low", t_if.busy, 0);
    @(negedge clk);
    t_trmt = 1'b0;
    check("t6_restart_send", t_if.send_byte, 1);
    check("t6_restart_busy", t_if.busy, 1);
    @(negedge clk);
    t_sent = 1'b1;
    @(negedge clk);
    t_sent = 1'b0;
    check("t6_send3", t_if.send_byte, 1);
    @(negedge clk);
    t_sent = 1'b1;
    @(negedge clk);
    t_sent = 1'b0;
    check("t6_done2", t_if.tx_done, 1);
    repeat (3) @(negedge clk);

    check("final_m_dones", m_dones, 3);
    check("final_l_dones", l_dones, 3);
    check("final_t_dones", t_dones, 2);
    check("final_t_sends", t_sends, 4);
    check("final_m_q", m_exp_q.size(), 0);
    check("final_l_q", l_exp_q.size(), 0);
    check("final_t_q", t_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_seq_nbyte.md
# tx_seq_nbyte

Parametrised multi-byte transmit sequencer, successor to the two-byte transmit state machine. On `trmt` it captures a NUM_BYTES-wide word and hands it one byte at a time to the serial8 byte transmitter, waiting for `byte_sent` between bytes. Byte order is selectable and the sequence can be aborted. It sits between the packet/command logic and serial8.

## Interface
- NUM_BYTES, 2, bytes per transfer; legal range 2..16
- LSB_FIRST, 0, 0 = most-significant byte first, 1 = least-significant byte first
- IW, $clog2(NUM_BYTES), derived width of `byte_idx`; not to be overridden
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- trmt  input  1  start request; sampled only in IDLE
- tx_data  input  8*NUM_BYTES  word to send; captured on the accepted `trmt` edge
- abort  input  1  terminate transfer in progress
- byte_sent  input  1  serial8 has finished the current byte
- byte_out  output  8  byte for serial8 to load
- send_byte  output  1  one-cycle pulse; serial8 loads `byte_out` and starts
- byte_idx  output  IW  ordinal of current byte in transmission order (0 = first)
- busy  output  1  high from the cycle after `trmt` acceptance until return to IDLE
- tx_done  output  1  one-cycle pulse after last `byte_sent`

## Operation
- States, in package typedef: IDLE, WAIT.
- IDLE, `trmt`=1: load shift register with `tx_data`; `byte_idx`<=0; next cycle `send_byte`=1, `busy`=1; go WAIT.
- WAIT, `byte_sent`=1 and `send_byte`=0:
  - `byte_idx`==NUM_BYTES-1: `tx_done` pulse next cycle, go IDLE.
  - otherwise: shift 8 bits (left if LSB_FIRST=0, right if 1); `byte_idx`++; `send_byte` pulse next cycle; stay WAIT.
- `byte_out` = shreg[8*NUM_BYTES-1 -: 8] when LSB_FIRST=0, shreg[7:0] when 1. Valid whenever `send_byte` is high and stable until the next shift.
- WAIT, `abort`=1: go IDLE next cycle, `busy`=0, no `tx_done`, no further `send_byte`. `abort` has priority over coincident `byte_sent`. `abort` in IDLE has no effect.
- `trmt` in WAIT is ignored; no queuing.
- `byte_sent` in IDLE, or in a cycle where `send_byte` is high, is ignored.
- `tx_data` changes after capture do not affect the transfer in flight.
- `byte_idx` never exceeds NUM_BYTES-1; no wrap.

## Timing
- Reset values: state IDLE, `send_byte` 0, `tx_done` 0, `busy` 0, `byte_idx` 0, shreg 0, so `byte_out` 0.
- `rst` mid-transfer: all of the above on the next edge; no `tx_done`, and the pending byte is abandoned.
- `trmt` at edge N means `send_byte` and the first byte valid in cycle N+1.
- `byte_sent` at edge M (not last) means next `send_byte` and next byte in cycle M+1.
- Last `byte_sent` at edge M means `tx_done`=1 and `busy`=0 in cycle M+1. `trmt` is accepted in that same cycle, so back-to-back transfers are allowed.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `tx_seq_pkg`: `seq_state_t` enum (IDLE, WAIT), byte width constant `BYTE_W`=8.
- One sub-module, `tx_shreg`: parametrised load/shift register with direction parameter and byte-select output, instantiated once.
- The FSM, `byte_idx` counter and output pulse registers live in the top module.

## Test plan
- NUM_BYTES=4, LSB_FIRST=0, `tx_data`=0xA1B2C3D4, `trmt`, with `byte_sent` 5 cycles after each `send_byte` -> `byte_out` A1, B2, C3, D4; `byte_idx` 0..3; exactly 4 `send_byte`; `tx_done` 1 cycle after 4th `byte_sent`.
- Same stimulus with LSB_FIRST=1 -> byte order D4, C3, B2, A1.
- Change `tx_data` to 0xFFFFFFFF and pulse `trmt` during WAIT -> the sequence still sends A1..D4; no restart, no extra `send_byte`.
- `abort` coincident with the 2nd `byte_sent` -> IDLE next cycle; `busy`=0; no `tx_done`; only 2 `send_byte` seen.
- `rst`=1 for one cycle after the 3rd `send_byte` -> all outputs at reset values next cycle; a subsequent `trmt` of 0x01020304 sends 01, 02, 03, 04.
- NUM_BYTES=2, `trmt` held high through `tx_done`, `byte_sent` asserted in the `send_byte` cycle -> coincident `byte_sent` ignored; second transfer starts in the `tx_done` cycle with `send_byte` the following cycle.
